// File: rtl/alarm_controller.sv
// ---------------------------------------------------------------------------
// alarm_controller
//
// Purpose:
//   Alarm sequencing FSM for the alarm clock. It compares the running time
//   against the committed alarm time, rings for a bounded number of seconds,
//   and schedules snoozes a fixed number of minutes after the button press.
//   Every output is registered, so an output changes one clk after the match,
//   snooze match or button that causes it.
//
// Parameters:
//   RING_SECS    tick_sec pulses spent ringing before auto-stop (1..255)
//   SNOOZE_MINS  minutes added to the current time on snooze (1..59)
//   MAX_SNOOZE   snoozes allowed per alarm event (0..3)
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high reset
//   enable        in   global enable; low freezes every register
//   tick_sec      in   one-clk pulse per second
//   alarm_en      in   alarm armed (level)
//   time_hours    in   current hours 0..23
//   time_minutes  in   current minutes 0..59
//   alarm_hours   in   committed alarm hours 0..23
//   alarm_minutes in   committed alarm minutes 0..59
//   btn_stop      in   one-clk pulse: stop alarm
//   btn_snooze    in   one-clk pulse: snooze alarm
//   ringing       out  high while RINGING
//   alarm_led     out  blinks (toggles per tick_sec) while RINGING, else 0
//   snooze_active out  high while SNOOZE
//   snooze_count  out  snoozes used in the current alarm event
// ---------------------------------------------------------------------------
module alarm_controller #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick_sec,
  input  logic       alarm_en,
  input  logic [4:0] time_hours,
  input  logic [5:0] time_minutes,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic       ringing,
  output logic       alarm_led,
  output logic       snooze_active,
  output logic [1:0] snooze_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] RING_LIM = 8'(RING_SECS);
  localparam logic [1:0] SNZ_LIM  = 2'(MAX_SNOOZE);
  localparam logic [6:0] SNZ_ADD  = 7'(SNOOZE_MINS);

  state_t     state_reg, state_next;
  logic [7:0] ring_cnt_reg, ring_cnt_next;
  logic       led_reg, led_next;
  logic       ringing_reg, ringing_next;
  logic       snooze_active_reg, snooze_active_next;
  logic [1:0] snz_cnt_reg, snz_cnt_next;
  logic [4:0] tgt_hr_reg, tgt_hr_next;
  logic [5:0] tgt_min_reg, tgt_min_next;

  logic       match;
  logic       smatch;
  logic [6:0] min_sum;
  logic [5:0] hr_sum;
  logic [4:0] snz_hr;
  logic [5:0] snz_min;

  assign match  = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
  assign smatch = (time_hours == tgt_hr_reg) && (time_minutes == tgt_min_reg);

  // Snooze target = now + SNOOZE_MINS. Minutes are summed 7 bits wide so the
  // carry past 59 is visible; at most one carry into hours is possible.
  always_comb begin
    min_sum = {1'b0, time_minutes} + SNZ_ADD;
    hr_sum  = {1'b0, time_hours} + 6'd1;
    snz_hr  = time_hours;
    snz_min = min_sum[5:0];
    if (min_sum >= 7'd60) begin
      snz_min = 6'(min_sum - 7'd60);
      snz_hr  = (hr_sum == 6'd24) ? 5'd0 : hr_sum[4:0];
    end
  end

  always_comb begin
    state_next    = state_reg;
    ring_cnt_next = ring_cnt_reg;
    led_next      = led_reg;
    snz_cnt_next  = snz_cnt_reg;
    tgt_hr_next   = tgt_hr_reg;
    tgt_min_next  = tgt_min_reg;

    // With enable low nothing moves; all defaults above are holds.
    if (enable) begin
      if (!alarm_en) begin
        // Disarming wins over every event in every state.
        state_next    = IDLE;
        ring_cnt_next = 8'd0;
        led_next      = 1'b0;
        snz_cnt_next  = 2'd0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (match) begin
              state_next    = RINGING;
              ring_cnt_next = 8'd0;
              led_next      = 1'b1;
              snz_cnt_next  = 2'd0;
            end
          end
          RINGING: begin
            // Priority: stop > snooze > timeout > blink toggle.
            if (btn_stop) begin
              state_next = DONE;
            end else if (btn_snooze) begin
              if (snz_cnt_reg < SNZ_LIM) begin
                state_next   = SNOOZE;
                snz_cnt_next = snz_cnt_reg + 2'd1;
                tgt_hr_next  = snz_hr;
                tgt_min_next = snz_min;
              end else begin
                state_next = DONE;
              end
            end else if (tick_sec) begin
              ring_cnt_next = ring_cnt_reg + 8'd1;
              if (ring_cnt_next == RING_LIM) begin
                state_next = DONE;
              end else begin
                led_next = ~led_reg;
              end
            end
          end
          SNOOZE: begin
            if (btn_stop) begin
              state_next = DONE;
            end else if (smatch) begin
              state_next    = RINGING;
              ring_cnt_next = 8'd0;
              led_next      = 1'b1;
            end
          end
          DONE: begin
            // Holding here until the alarm minute passes prevents retrigger.
            if (!match) begin
              state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end

    // Status outputs follow the state being entered so they land on the
    // same edge as the transition; the LED is dark outside RINGING.
    ringing_next       = (state_next == RINGING);
    snooze_active_next = (state_next == SNOOZE);
    if (state_next != RINGING) begin
      led_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      ring_cnt_reg      <= 8'd0;
      led_reg           <= 1'b0;
      ringing_reg       <= 1'b0;
      snooze_active_reg <= 1'b0;
      snz_cnt_reg       <= 2'd0;
      tgt_hr_reg        <= 5'd0;
      tgt_min_reg       <= 6'd0;
    end else begin
      state_reg         <= state_next;
      ring_cnt_reg      <= ring_cnt_next;
      led_reg           <= led_next;
      ringing_reg       <= ringing_next;
      snooze_active_reg <= snooze_active_next;
      snz_cnt_reg       <= snz_cnt_next;
      tgt_hr_reg        <= tgt_hr_next;
      tgt_min_reg       <= tgt_min_next;
    end
  end

  assign ringing       = ringing_reg;
  assign alarm_led     = led_reg;
  assign snooze_active = snooze_active_reg;
  assign snooze_count  = snz_cnt_reg;

endmodule

// File: tb/tb_alarm_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_controller
//
// Directed testbench for alarm_controller with default parameters
// (RING_SECS=60, SNOOZE_MINS=5, MAX_SNOOZE=3). Each step drives the inputs,
// pushes the outputs expected after the next clock edge onto a scoreboard
// queue, and after the edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_alarm_controller;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       tick_sec;
  logic       alarm_en;
  logic [4:0] time_hours;
  logic [5:0] time_minutes;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       btn_stop;
  logic       btn_snooze;
  logic       ringing;
  logic       alarm_led;
  logic       snooze_active;
  logic [1:0] snooze_count;

  typedef struct {
    string      tag;
    logic       r;
    logic       l;
    logic       s;
    logic [1:0] c;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  alarm_controller dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .tick_sec      (tick_sec),
    .alarm_en      (alarm_en),
    .time_hours    (time_hours),
    .time_minutes  (time_minutes),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .btn_stop      (btn_stop),
    .btn_snooze    (btn_snooze),
    .ringing       (ringing),
    .alarm_led     (alarm_led),
    .snooze_active (snooze_active),
    .snooze_count  (snooze_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic r, input logic l,
                      input logic s, input logic [1:0] c);
    exp_t e;
    e.tag = tag;
    e.r   = r;
    e.l   = l;
    e.s   = s;
    e.c   = c;
    sb.push_back(e);
  endtask

  task automatic check_outputs();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_assert++;
      assert (ringing === e.r) else begin
        n_fail++;
        $error("FAIL %s ringing: got %b expected %b", e.tag, ringing, e.r);
      end
      n_assert++;
      assert (alarm_led === e.l) else begin
        n_fail++;
        $error("FAIL %s alarm_led: got %b expected %b", e.tag, alarm_led, e.l);
      end
      n_assert++;
      assert (snooze_active === e.s) else begin
        n_fail++;
        $error("FAIL %s snooze_active: got %b expected %b", e.tag, snooze_active, e.s);
      end
      n_assert++;
      assert (snooze_count === e.c) else begin
        n_fail++;
        $error("FAIL %s snooze_count: got %0d expected %0d", e.tag, snooze_count, e.c);
      end
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_time(input int h, input int m);
    time_hours   = 5'(h);
    time_minutes = 6'(m);
  endtask

  task automatic set_alarm(input int h, input int m);
    alarm_hours   = 5'(h);
    alarm_minutes = 6'(m);
  endtask

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_r;
    logic exp_l;

    reset      = 1'b1;
    enable     = 1'b1;
    tick_sec   = 1'b0;
    alarm_en   = 1'b0;
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
    set_time(7, 29);
    set_alarm(7, 30);

    // Reset state
    push("reset0", 0, 0, 0, 2'd0); step();
    push("reset1", 0, 0, 0, 2'd0); step();
    reset = 1'b0;

    // 1: ring at 07:30, blink per tick, auto-stop after 60 ticks
    alarm_en = 1'b1;
    push("t1_idle", 0, 0, 0, 2'd0); step();
    set_time(7, 30);
    push("t1_ring", 1, 1, 0, 2'd0); step();
    for (int i = 1; i <= 60; i++) begin
      exp_r = (i < 60);
      exp_l = (i < 60) && (i % 2 == 0);
      tick_sec = 1'b1;
      push($sformatf("t1_tick%0d", i), exp_r, exp_l, 0, 2'd0); step();
      tick_sec = 1'b0;
      push($sformatf("t1_gap%0d", i), exp_r, exp_l, 0, 2'd0); step();
    end
    push("t1_done_hold", 0, 0, 0, 2'd0); step();
    set_time(7, 31);
    push("t1_to_idle", 0, 0, 0, 2'd0); step();
    set_time(7, 30);
    push("t1_rering", 1, 1, 0, 2'd0); step();
    btn_stop = 1'b1;
    push("t1_stop", 0, 0, 0, 2'd0); step();
    btn_stop = 1'b0;

    // 2: snooze at 23:58 wraps to 00:03
    set_alarm(23, 58);
    set_time(23, 57);
    push("t2_idle", 0, 0, 0, 2'd0); step();
    set_time(23, 58);
    push("t2_ring", 1, 1, 0, 2'd0); step();
    btn_snooze = 1'b1;
    push("t2_snooze", 0, 0, 1, 2'd1); step();
    btn_snooze = 1'b0;
    set_alarm(10, 0);  // alarm edit must not move the latched target
    set_time(23, 59);
    push("t2_wait1", 0, 0, 1, 2'd1); step();
    set_time(0, 2);
    push("t2_wait2", 0, 0, 1, 2'd1); step();
    set_time(0, 3);
    push("t2_rering", 1, 1, 0, 2'd1); step();

    // 3: snooze up to the limit, then a 4th snooze stops
    btn_snooze = 1'b1;
    push("t3_snz2", 0, 0, 1, 2'd2); step();
    btn_snooze = 1'b0;
    set_time(0, 8);
    push("t3_ring2", 1, 1, 0, 2'd2); step();
    btn_snooze = 1'b1;
    push("t3_snz3", 0, 0, 1, 2'd3); step();
    btn_snooze = 1'b0;
    set_time(0, 13);
    push("t3_ring3", 1, 1, 0, 2'd3); step();
    btn_snooze = 1'b1;
    push("t3_snz4_stop", 0, 0, 0, 2'd3); step();
    btn_snooze = 1'b0;
    set_time(0, 18);
    push("t3_no_ring", 0, 0, 0, 2'd3); step();

    // 4: stop and snooze together -> DONE, count unchanged, no re-ring
    set_alarm(7, 30);
    set_time(7, 30);
    push("t4_ring", 1, 1, 0, 2'd0); step();
    btn_snooze = 1'b1;
    push("t4_snooze", 0, 0, 1, 2'd1); step();
    btn_snooze = 1'b0;
    set_time(7, 35);
    push("t4_rering", 1, 1, 0, 2'd1); step();
    set_time(7, 30);
    push("t4_ring_hold", 1, 1, 0, 2'd1); step();
    btn_stop   = 1'b1;
    btn_snooze = 1'b1;
    push("t4_both", 0, 0, 0, 2'd1); step();
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("t4_no_rering%0d", i), 0, 0, 0, 2'd1); step();
    end

    // 5: alarm_en drop during SNOOZE; enable freeze while ringing
    set_time(7, 31);
    push("t5_idle", 0, 0, 0, 2'd1); step();
    set_alarm(8, 0);
    set_time(8, 0);
    push("t5_ring", 1, 1, 0, 2'd0); step();
    btn_snooze = 1'b1;
    push("t5_snooze", 0, 0, 1, 2'd1); step();
    btn_snooze = 1'b0;
    alarm_en = 1'b0;
    push("t5_disarm", 0, 0, 0, 2'd0); step();
    push("t5_disarm_hold", 0, 0, 0, 2'd0); step();
    alarm_en = 1'b1;
    push("t5_rearm_ring", 1, 1, 0, 2'd0); step();
    tick_sec = 1'b1;
    push("t5_tick", 1, 0, 0, 2'd0); step();
    enable   = 1'b0;
    btn_stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("t5_frozen%0d", i), 1, 0, 0, 2'd0); step();
    end
    btn_stop = 1'b0;
    enable   = 1'b1;
    push("t5_unfreeze_tick", 1, 1, 0, 2'd0); step();
    tick_sec = 1'b0;

    // 6: reset mid-RINGING and mid-SNOOZE
    reset = 1'b1;
    push("t6_reset_ring", 0, 0, 0, 2'd0); step();
    push("t6_reset_hold", 0, 0, 0, 2'd0); step();
    reset = 1'b0;
    push("t6_match_persists", 1, 1, 0, 2'd0); step();
    btn_snooze = 1'b1;
    push("t6_snooze", 0, 0, 1, 2'd1); step();
    btn_snooze = 1'b0;
    reset = 1'b1;
    set_time(8, 1);
    push("t6_reset_snooze", 0, 0, 0, 2'd0); step();
    reset = 1'b0;
    push("t6_no_match", 0, 0, 0, 2'd0); step();
    push("t6_no_match2", 0, 0, 0, 2'd0); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
